// File: rtl/ricevitore_seriale_parallelo.sv
// Serial-to-parallel receiver: MSB-first shift register with a bit counter, plus
// an output handshake FSM (IDLE/HOLD/RELEASE) with a sticky overrun flag.
module ricevitore_seriale_parallelo #(
  parameter int unsigned N = 4
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 s,
  input  logic                 bv,
  input  logic                 sof,
  input  logic                 rfd,
  output logic [N-1:0]         z,
  output logic                 dav_,
  output logic                 ovr,
  output logic [$clog2(N):0]   cnt
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   sr_q;
  logic [N-1:0]   w_c;
  logic           complete_c;
  logic           load_c;
  logic           ovr_set_c;

  // A start-of-frame bit restarts the count at 1, so it can never complete a word.
  assign w_c        = {sr_q[N-2:0], s};
  assign complete_c = bv && !sof && (cnt == CW'(N - 1));

  // Receive side: never stalls, independent of the handshake state.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sr_q <= '0;
      cnt  <= '0;
    end else if (bv) begin
      if (sof) begin
        sr_q <= {{(N - 1){1'b0}}, s};
        cnt  <= CW'(1);
      end else begin
        sr_q <= w_c;
        cnt  <= complete_c ? '0 : cnt + CW'(1);
      end
    end
  end

  // Output FSM state register and registered outputs.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      z       <= '0;
      dav_    <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        z <= w_c;
      end
      dav_ <= (state_d != HOLD);
      ovr  <= ovr | ovr_set_c;
    end
  end

  // Next-state logic: a completed word is accepted only when the consumer is free.
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    ovr_set_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (complete_c) begin
          load_c  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (complete_c) begin
          ovr_set_c = 1'b1;
        end
        if (!rfd) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rfd) begin
          if (complete_c) begin
            load_c  = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else if (complete_c) begin
          ovr_set_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ricevitore_seriale_parallelo.sv
// Directed bench for ricevitore_seriale_parallelo (N=4): framing, handshake,
// overrun, sof resync, bv gaps and asynchronous reset.
module tb_ricevitore_seriale_parallelo;

  logic       clock;
  logic       reset_;
  logic       s;
  logic       bv;
  logic       sof;
  logic       rfd;
  logic [3:0] z;
  logic       dav_;
  logic       ovr;
  logic [2:0] cnt;

  int checks;
  int errors;

  ricevitore_seriale_parallelo #(.N(4)) dut (
    .clock (clock),
    .reset_(reset_),
    .s     (s),
    .bv    (bv),
    .sof   (sof),
    .rfd   (rfd),
    .z     (z),
    .dav_  (dav_),
    .ovr   (ovr),
    .cnt   (cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit cycle, then settle just after the rising edge.
  task automatic cyc(input logic b, input logic sf, input logic sd, input logic r);
    bv  = b;
    sof = sf;
    s   = sd;
    rfd = r;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ez, input logic ed,
                         input logic eo, input logic [2:0] ec);
    chk({tag, "_z"}, 16'(z), 16'(ez));
    chk({tag, "_dav"}, 16'(dav_), 16'(ed));
    chk({tag, "_ovr"}, 16'(ovr), 16'(eo));
    chk({tag, "_cnt"}, 16'(cnt), 16'(ec));
  endtask

  // Mid-cycle asynchronous reset pulse, checked while still asserted.
  task automatic mid_reset(input string tag);
    #2;
    reset_ = 1'b0;
    #1;
    chk_out(tag, 4'b0000, 1'b1, 1'b0, 3'd0);
    reset_ = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_ = 1'b0;
    bv = 1'b0; sof = 1'b0; s = 1'b0; rfd = 1'b1;
    #12;
    chk_out("reset", 4'b0000, 1'b1, 1'b0, 3'd0);
    reset_ = 1'b1;
    #1;
    chk_out("post_release", 4'b0000, 1'b1, 1'b0, 3'd0);

    // Basic frame 1011 with sof on the MSB
    cyc(1, 1, 1, 1); chk_out("f1_b1", 4'b0000, 1'b1, 1'b0, 3'd1);
    cyc(1, 0, 0, 1); chk("f1_b2_cnt", 16'(cnt), 16'd2);
    cyc(1, 0, 1, 1); chk("f1_b3_cnt", 16'(cnt), 16'd3);
    cyc(1, 0, 1, 1); chk_out("f1_done", 4'b1011, 1'b0, 1'b0, 3'd0);

    // Handshake: rfd low releases dav_, rfd high returns to IDLE
    cyc(0, 0, 0, 0); chk_out("hs_rel", 4'b1011, 1'b1, 1'b0, 3'd0);
    cyc(0, 0, 0, 1); chk_out("hs_idle", 4'b1011, 1'b1, 1'b0, 3'd0);

    // Overrun while held in HOLD
    cyc(1, 0, 1, 1); cyc(1, 0, 0, 1); cyc(1, 0, 1, 1); cyc(1, 0, 1, 1);
    chk_out("ov_w1", 4'b1011, 1'b0, 1'b0, 3'd0);
    cyc(1, 0, 0, 1); cyc(1, 0, 1, 1); cyc(1, 0, 1, 1);
    chk("ov_pre_dav", 16'(dav_), 16'd0);
    cyc(1, 0, 0, 1);
    chk_out("ov_hit", 4'b1011, 1'b0, 1'b1, 3'd0);
    cyc(0, 0, 0, 0); chk("ov_rel_dav", 16'(dav_), 16'd1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 1, 1); cyc(1, 0, 1, 1);
    chk_out("ov_next", 4'b0011, 1'b0, 1'b1, 3'd0);

    // sof discards partial frame
    mid_reset("rst1");
    cyc(1, 1, 1, 1); cyc(1, 0, 1, 1); chk("sof_part_cnt", 16'(cnt), 16'd2);
    cyc(1, 1, 0, 1); chk("sof_restart_cnt", 16'(cnt), 16'd1);
    cyc(1, 0, 1, 1); cyc(1, 0, 0, 1);
    chk("sof_pre_dav", 16'(dav_), 16'd1);
    cyc(1, 0, 1, 1);
    chk_out("sof_done", 4'b0101, 1'b0, 1'b0, 3'd0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);

    // bv gaps: ignored s values deliberately differ from the carried bits
    cyc(1, 0, 1, 1); chk("gap_c1", 16'(cnt), 16'd1);
    cyc(0, 0, 1, 1); chk("gap_c2", 16'(cnt), 16'd1);
    cyc(0, 0, 0, 1); chk("gap_c3", 16'(cnt), 16'd1);
    cyc(1, 0, 0, 1); chk("gap_c4", 16'(cnt), 16'd2);
    cyc(1, 0, 0, 1); chk("gap_c5", 16'(cnt), 16'd3);
    cyc(0, 0, 1, 1); chk("gap_c6", 16'(cnt), 16'd3);
    cyc(1, 0, 1, 1);
    chk_out("gap_done", 4'b1001, 1'b0, 1'b0, 3'd0);

    // Reset during HOLD with a partial frame of two bits
    cyc(1, 0, 1, 1); cyc(1, 0, 1, 1);
    chk_out("hold_part", 4'b1001, 1'b0, 1'b0, 3'd2);
    mid_reset("rst2");
    cyc(1, 0, 1, 1); cyc(1, 0, 1, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    chk_out("after_rst", 4'b1100, 1'b0, 1'b0, 3'd0);

    // Overrun in RELEASE with rfd low, then acceptance on the rfd-high edge
    cyc(0, 0, 0, 0); chk("rel_dav", 16'(dav_), 16'd1);
    cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
    chk_out("rel_ovr", 4'b1100, 1'b1, 1'b1, 3'd0);
    cyc(1, 0, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 1);
    chk_out("rel_accept", 4'b0111, 1'b0, 1'b1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ricevitore_seriale_parallelo.md
RICEVITORE_SERIALE_PARALLELO -- requirements
Module: ricevitore_seriale_parallelo

Interface
REQ-001 SHALL have parameter: N, 4, word width in bits (legal range 2..16).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: reset_  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: s  input  1  serial data bit; MSB first.
REQ-005 SHALL have port: bv  input  1  bit valid; s sampled only on posedges where bv=1.
REQ-006 SHALL have port: sof  input  1  start of frame; meaningful only with bv=1; marks the current bit as the MSB.
REQ-007 SHALL have port: rfd  input  1  ready-for-data from the downstream consumer, active-high level.
REQ-008 SHALL have port: z  output  N  received word; stable while dav_=0.
REQ-009 SHALL have port: dav_  output  1  data-available, active-low.
REQ-010 SHALL have port: ovr  output  1  sticky overrun flag.
REQ-011 SHALL have port: cnt  output  log2(N)+1  number of bits held in the current partial frame, 0..N-1.

Function
REQ-012 Receive side SHALL be an N-bit shift register SR and a bit counter CNT: on posedge with bv=1, SR <= {SR[N-2:0], s}.
REQ-013 CNT SHALL increment by 1 per accepted bit; with bv=0, SR and CNT SHALL hold.
REQ-014 bv=1 with sof=1 SHALL discard any partial frame: SR <= {0..0, s}, CNT <= 1; the previous partial bits are lost without flag.
REQ-015 bv=1 with sof=0 while CNT=0 SHALL be accepted as the MSB of a new frame (sof is optional for the first frame after reset).
REQ-016 The N-th accepted bit (CNT=N-1, bv=1) SHALL complete the word W = {SR[N-2:0], s}; CNT SHALL wrap to 0 on that same edge.
REQ-017 Output side SHALL be a 3-state FSM: IDLE (dav_=1), HOLD (dav_=0), RELEASE (dav_=1).
REQ-018 IDLE: on word completion, z <= W and go to HOLD on the same edge; dav_ falls 1 cycle after the completing bit.
REQ-019 HOLD: z and dav_=0 SHALL hold until an edge with rfd=0 is sampled; then go to RELEASE.
REQ-020 RELEASE: remain until an edge with rfd=1 is sampled; then go to IDLE.
REQ-021 Word completion in IDLE, or in RELEASE on the edge where rfd=1 is sampled, SHALL be accepted: z <= W, next state HOLD.
REQ-022 Word completion in HOLD, or in RELEASE with rfd=0, SHALL be an overrun: W discarded, z unchanged, ovr <= 1.
REQ-023 ovr SHALL remain 1 until reset; overrun SHALL NOT disturb the FSM state or the receive side.
REQ-024 The receive side SHALL never stall; bits arriving during HOLD/RELEASE SHALL still be shifted and counted.
REQ-025 z SHALL change only on the IDLE/RELEASE-to-HOLD transition.
REQ-026 cnt SHALL equal CNT directly (registered, no combinational path from inputs).
REQ-027 Latency: completing bit at edge k -> z valid, dav_=0 after edge k; minimum frame-to-frame spacing without overrun is N bit cycles provided the consumer completes the handshake within N-1 cycles.

Reset
REQ-028 reset_=0 SHALL immediately, independent of clock, force SR=0, CNT=0, z=0, dav_=1, ovr=0, FSM=IDLE.
REQ-029 Reset mid-frame or mid-handshake SHALL abandon the partial frame and pending word with no flag; the first bv=1 after reset_ rises is the MSB of a new frame.
REQ-030 All outputs SHALL hold reset values until the first posedge after reset_=1.

Verification
REQ-031 N=4, reset, send 1,0,1,1 with bv=1 on 4 consecutive edges (sof on first), rfd=1 -> after 4th edge z=1011, dav_=0, cnt=0, ovr=0.
REQ-032 From REQ-031 state, drive rfd=0 one cycle then rfd=1 -> dav_=1 after the rfd=0 edge, FSM=IDLE after the rfd=1 edge, z stays 1011.
REQ-033 Send 1011, hold rfd=1 (no handshake), send 0110 -> ovr=1, z=1011, dav_=0; after handshake and sending 0011 -> z=0011, ovr still 1.
REQ-034 Send 1,1 then sof=1 with bits 0,1,0,1 -> z=0101 (partial 11 discarded), ovr=0.
REQ-035 Interleave bv=0 gaps (pattern bv=1,0,0,1,1,0,1) carrying 1,0,0,1 -> z=1001; cnt reads 1,1,1,2,3,3,0.
REQ-036 Assert reset_=0 mid-clock-cycle during HOLD with cnt=2 -> dav_=1, z=0000, cnt=0 immediately; next frame 1100 -> z=1100.
